approx_adder_err_monitor: RTL and testbench

- Sequential error-characterisation block that sits at the output of an approximate parallel-prefix adder (Brent-Kung, lower-K-bit approximation), i.e. the consumer end of that adder's interface.
- For each operand pair it takes the adder's approximate result, computes the exact sum internally, and accumulates error metrics over a run of 2^LOG2_SAMPLES samples.
- Used in silicon bring-up and in FPGA PPA/accuracy sweeps.

---
 rtl/approx_mon_pkg.sv | 19 +
 rtl/approx_err_dist.sv | 19 +
 rtl/approx_adder_err_monitor.sv | 129 ++++++++++++
 tb/tb_approx_adder_err_monitor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/approx_mon_pkg.sv
// approx_mon_pkg: shared state encoding and width derivations for the approximate-adder error monitor.
package approx_mon_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   localparam int WIDTH_DEF        = 16;
   localparam int LOG2_SAMPLES_DEF = 10;
   localparam int ED_W    = WIDTH_DEF + 1;
   localparam int SUM_W   = ED_W + LOG2_SAMPLES_DEF;
   localparam int SQ_W    = 2 * ED_W + LOG2_SAMPLES_DEF;
   localparam int SAMPLES = 1 << LOG2_SAMPLES_DEF;
   function automatic int ed_width(input int width);
      return width + 1;
   endfunction
   function automatic int sum_width(input int width, input int log2_samples);
      return width + 1 + log2_samples;
   endfunction
   function automatic int sq_width(input int width, input int log2_samples);
      return 2 * (width + 1) + log2_samples;
   endfunction
endpackage

// File: rtl/approx_err_dist.sv
// approx_err_dist: exact sum of the operands and its absolute distance from the approximate result.
module approx_err_dist #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             cin_i,
   input  logic [WIDTH:0]   approx_sum_i,
   output logic [WIDTH:0]   ed_o
);
   logic [WIDTH:0]   exact;
   logic [WIDTH+1:0] diff;
   logic [WIDTH+1:0] neg;
   assign exact = {1'b0, op_a_i} + {1'b0, op_b_i} + {{WIDTH{1'b0}}, cin_i};
   // one extra bit so the sign of exact - approx survives
   assign diff  = {1'b0, exact} - {1'b0, approx_sum_i};
   assign neg   = -diff;
   assign ed_o  = diff[WIDTH+1] ? neg[WIDTH:0] : diff[WIDTH:0];
endmodule

// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor: accumulates error-distance statistics of an approximate adder over 2^LOG2_SAMPLES samples.
// Define ERR_MSE_EN to add a squared-error accumulator behind an extra multiply stage.
module approx_adder_err_monitor
   import approx_mon_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int LOG2_SAMPLES = 10
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [WIDTH-1:0]                  op_a,
   input  logic [WIDTH-1:0]                  op_b,
   input  logic                              cin,
   input  logic [WIDTH:0]                    approx_sum,
   output logic                              busy,
   output logic                              done,
   output logic [LOG2_SAMPLES:0]             err_count,
   output logic [WIDTH+LOG2_SAMPLES:0]       ed_sum,
   output logic [WIDTH:0]                    ed_max,
   output logic [WIDTH:0]                    ed_mean,
   output logic [2*WIDTH+1+LOG2_SAMPLES:0]   sq_sum
);
   localparam int EW = ed_width(WIDTH);
   localparam int SW = sum_width(WIDTH, LOG2_SAMPLES);
   localparam int QW = sq_width(WIDTH, LOG2_SAMPLES);
   localparam int CW = LOG2_SAMPLES + 1;
`ifdef ERR_MSE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   state_e                  state_q, state_d;
   logic [LOG2_SAMPLES-1:0] cnt_q, cnt_d;
   logic [1:0]              dcnt_q, dcnt_d;
   logic                    v1_q;
   logic [EW-1:0]           ed1_q, ed1_d, ed;
   logic [CW-1:0]           err_q, err_d;
   logic [SW-1:0]           sum_q, sum_d;
   logic [EW-1:0]           max_q, max_d;
   logic                    accept, clear, last, drain_end, av;
   logic [EW-1:0]           aed;

   approx_err_dist #(.WIDTH(WIDTH)) u_dist (
      .op_a_i      (op_a),
      .op_b_i      (op_b),
      .cin_i       (cin),
      .approx_sum_i(approx_sum),
      .ed_o        (ed)
   );

   assign in_ready  = state_q == RUN;
   assign busy      = state_q == RUN || state_q == DRAIN;
   assign done      = state_q == DONE;
   assign err_count = err_q;
   assign ed_sum    = sum_q;
   assign ed_max    = max_q;
   assign ed_mean   = sum_q[SW-1:LOG2_SAMPLES];

   always_comb begin
      accept    = in_valid && in_ready;
      clear     = start && (state_q == IDLE || state_q == DONE);
      last      = accept && cnt_q == '1;
      drain_end = state_q == DRAIN && dcnt_q == 2'(LAT - 1);
      state_d   = clear ? RUN : last ? DRAIN : drain_end ? DONE : state_q;
      cnt_d     = clear ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
      dcnt_d    = state_q == DRAIN ? dcnt_q + 1'b1 : 2'd0;
      ed1_d     = accept ? ed : ed1_q;
      err_d     = clear ? '0 : av ? err_q + CW'(aed != '0) : err_q;
      sum_d     = clear ? '0 : av ? sum_q + SW'(aed) : sum_q;
      max_d     = clear ? '0 : (av && aed > max_q) ? aed : max_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dcnt_q  <= '0;
         v1_q    <= 1'b0;
         ed1_q   <= '0;
         err_q   <= '0;
         sum_q   <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dcnt_q  <= dcnt_d;
         v1_q    <= accept;
         ed1_q   <= ed1_d;
         err_q   <= err_d;
         sum_q   <= sum_d;
         max_q   <= max_d;
      end
   end

`ifdef ERR_MSE_EN
   localparam int MW = 2 * EW;
   logic          vm_q;
   logic [EW-1:0] edm_q;
   logic [MW-1:0] sqm_q, sqm_d;
   logic [QW-1:0] sq_q, sq_d;
   assign av     = vm_q;
   assign aed    = edm_q;
   assign sq_sum = sq_q;
   always_comb begin
      sqm_d = MW'(ed1_q) * MW'(ed1_q);
      sq_d  = clear ? '0 : av ? sq_q + QW'(sqm_q) : sq_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vm_q  <= 1'b0;
         edm_q <= '0;
         sqm_q <= '0;
         sq_q  <= '0;
      end else begin
         vm_q  <= v1_q;
         edm_q <= ed1_q;
         sqm_q <= sqm_d;
         sq_q  <= sq_d;
      end
   end
`else
   assign av     = v1_q;
   assign aed    = ed1_q;
   assign sq_sum = '0;
`endif
endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// tb_approx_adder_err_monitor: directed-vector bench for the error monitor at WIDTH=16, LOG2_SAMPLES=2.
module tb_approx_adder_err_monitor;
   localparam int W = 16;
   localparam int L = 2;
`ifdef ERR_MSE_EN
   localparam int LAT = 3;
   localparam bit MSE = 1'b1;
`else
   localparam int LAT = 2;
   localparam bit MSE = 1'b0;
`endif
   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [W-1:0]       op_a = '0;
   logic [W-1:0]       op_b = '0;
   logic               cin = 1'b0;
   logic [W:0]         approx_sum = '0;
   logic               busy, done;
   logic [L:0]         err_count;
   logic [W+L:0]       ed_sum;
   logic [W:0]         ed_max, ed_mean;
   logic [2*W+1+L:0]   sq_sum;
   int                 n_vec = 0;
   int                 n_bad = 0;

   approx_adder_err_monitor #(.WIDTH(W), .LOG2_SAMPLES(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
      .approx_sum(approx_sum),
      .busy      (busy),
      .done      (done),
      .err_count (err_count),
      .ed_sum    (ed_sum),
      .ed_max    (ed_max),
      .ed_mean   (ed_mean),
      .sq_sum    (sq_sum)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic [W:0] s);
      op_a = a;
      op_b = b;
      cin = c;
      approx_sum = s;
      in_valid = 1'b1;
      check("in_ready_run", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done;
      int k = 0;
      check("busy_drain", busy, 1);
      while (!done && k < 50) begin
         tick();
         k++;
      end
      check("done_latency", k, LAT);
      check("busy_after_done", busy, 0);
      check("in_ready_done", in_ready, 0);
   endtask

   task automatic check_res(input string tag, input int e, input int s, input int m, input int q);
      check({tag, "_err_count"}, err_count, e);
      check({tag, "_ed_sum"}, ed_sum, s);
      check({tag, "_ed_max"}, ed_max, m);
      check({tag, "_ed_mean"}, ed_mean, s >> L);
      check({tag, "_sq_sum"}, sq_sum, MSE ? q : 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check_res(tag, 0, 0, 0, 0);
   endtask

   initial begin
      in_valid = 1'b1;
      repeat (3) tick();
      check_zero("reset");
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);
      in_valid = 1'b0;

      // exact run
      pulse_start();
      check("run_busy", busy, 1);
      send(16'h0001, 16'h0002, 1'b0, 17'h00003);
      send(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
      send(16'h1234, 16'h4321, 1'b1, 17'h05556);
      send(16'h8000, 16'h8000, 1'b1, 17'h10001);
      wait_done();
      check_res("exact", 0, 0, 0, 0);

      // known approximation, with an ignored start mid-run
      pulse_start();
      send(16'h00FF, 16'h0001, 1'b0, 17'h000FC);
      send(16'h00FF, 16'h0001, 1'b0, 17'h000FC);
      pulse_start();
      check("ignored_start_ready", in_ready, 1);
      send(16'h00FF, 16'h0001, 1'b0, 17'h000FC);
      send(16'h00FF, 16'h0001, 1'b0, 17'h000FC);
      wait_done();
      check_res("approx", 4, 16, 4, 64);
      repeat (3) tick();
      check("done_hold", done, 1);
      check("sum_hold", ed_sum, 16);

      // start in DONE clears; mixed errors with bubbles
      pulse_start();
      check("restart_done", done, 0);
      check("restart_sum", ed_sum, 0);
      check("restart_err", err_count, 0);
      send(16'h0005, 16'h0006, 1'b0, 17'h0000B);
      repeat (2) tick();
      send(16'h0010, 16'h0010, 1'b0, 17'h00024);
      repeat (2) tick();
      send(16'h1000, 16'h0200, 1'b1, 17'h01101);
      repeat (3) tick();
      check("bubble_still_run", in_ready, 1);
      check("bubble_not_done", done, 0);
      send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE);
      wait_done();
      check_res("mixed", 3, 32'h105, 32'h100, 32'h10011);

      // asynchronous reset mid-run, then a clean run
      pulse_start();
      send(16'h00FF, 16'h0001, 1'b0, 17'h000FC);
      send(16'h00FF, 16'h0001, 1'b0, 17'h000FC);
      tick();
      rst_n = 1'b0;
      #1;
      check_zero("abort");
      tick();
      rst_n = 1'b1;
      tick();
      check("post_abort_idle", in_ready, 0);
      pulse_start();
      repeat (4) send(16'h00FF, 16'h0001, 1'b0, 17'h000FF);
      wait_done();
      check_res("clean", 4, 4, 1, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
